// File: rtl/iconn_pkg.sv
// Shared types and helpers for the VP interconnect shuffle-exchange stages.
package iconn_pkg;

  localparam int MAX_NAW = 16;

  typedef logic [MAX_NAW-1:0] node_addr_t;

  function automatic int port_num(input int naw);
    return 1 << naw;
  endfunction

  // Stage s of an omega network steers on address bit naw-1-s (MSB first).
  function automatic logic route_bit(input node_addr_t addr, input int naw, input int stage);
    int idx;
    idx = naw - 1 - stage;
    if (idx < 0 || idx >= MAX_NAW) return 1'b0;
    return addr[idx[$clog2(MAX_NAW)-1:0]];
  endfunction

endpackage

// File: rtl/iconn_exchange_stage_if.sv
// Token bus into and out of one exchange stage; slave is the stage side.
interface iconn_exchange_stage_if
  import iconn_pkg::*;
#(
  parameter int NODE_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH      = 64
);
  localparam int PORT_NUM = port_num(NODE_ADDR_WIDTH);

  logic [PORT_NUM-1:0][NODE_ADDR_WIDTH-1:0] ain;
  logic [PORT_NUM-1:0][DATA_WIDTH-1:0]      din;
  logic [PORT_NUM-1:0]                      din_valid;
  logic [PORT_NUM-1:0]                      din_ready;
  logic [PORT_NUM-1:0][NODE_ADDR_WIDTH-1:0] aout;
  logic [PORT_NUM-1:0][DATA_WIDTH-1:0]      dout;
  logic [PORT_NUM-1:0]                      dout_valid;
  logic [PORT_NUM-1:0]                      dout_ready;

  modport master (
    output ain, din, din_valid, dout_ready,
    input  din_ready, aout, dout, dout_valid
  );

  modport slave (
    input  ain, din, din_valid, dout_ready,
    output din_ready, aout, dout, dout_valid
  );

endinterface

// File: rtl/iconn_exchange_switch.sv
// One registered 2x2 exchange switch: route by one address bit, round-robin on
// same-target conflicts, 1-entry output registers with same-cycle drain+refill.
module iconn_exchange_switch
  import iconn_pkg::*;
#(
  parameter int NODE_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH      = 64,
  parameter int STAGE_IDX       = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [1:0][NODE_ADDR_WIDTH-1:0] ain,
  input  logic [1:0][DATA_WIDTH-1:0]      din,
  input  logic [1:0]                      din_valid,
  output logic [1:0]                      din_ready,
  output logic [1:0][NODE_ADDR_WIDTH-1:0] aout,
  output logic [1:0][DATA_WIDTH-1:0]      dout,
  output logic [1:0]                      dout_valid,
  input  logic [1:0]                      dout_ready,
  output logic                            conflict
);

  typedef struct packed {
    logic [NODE_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]      data;
  } tok_t;

  tok_t [1:0] tok_in, tok_q;
  logic [1:0] vld_q;
  logic [1:0] rbit, free, xfer, load, src;
  logic       prio_q, clash;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rbit[i]   = route_bit(node_addr_t'(ain[i]), NODE_ADDR_WIDTH, STAGE_IDX);
      free[i]   = !vld_q[i] | dout_ready[i];
      tok_in[i] = '{addr: ain[i], data: din[i]};
    end
  end

  assign clash = &din_valid & (rbit[0] == rbit[1]);

  // On a clash only the priority input may see ready; held low through reset.
  always_comb begin
    din_ready = '0;
    if (rst_n) begin
      if (clash) begin
        din_ready[prio_q] = free[rbit[prio_q]];
      end else begin
        din_ready[0] = free[rbit[0]];
        din_ready[1] = free[rbit[1]];
      end
    end
  end

  assign xfer     = din_valid & din_ready;
  assign conflict = clash & |xfer;

  always_comb begin
    load = '0;
    src  = '0;
    for (int o = 0; o < 2; o++) begin
      for (int i = 0; i < 2; i++) begin
        if (xfer[i] && (rbit[i] == o[0])) begin
          load[o] = 1'b1;
          src[o]  = i[0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      tok_q <= '0;
    end else begin
      for (int o = 0; o < 2; o++) begin
        if (load[o]) begin
          vld_q[o] <= 1'b1;
          tok_q[o] <= tok_in[src[o]];
        end else if (dout_ready[o]) begin
          vld_q[o] <= 1'b0;
        end
      end
    end
  end

  // Priority passes to the loser only once the winner has actually moved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       prio_q <= 1'b0;
    else if (clash && xfer[prio_q])   prio_q <= ~prio_q;
  end

  always_comb begin
    for (int o = 0; o < 2; o++) begin
      aout[o] = tok_q[o].addr;
      dout[o] = tok_q[o].data;
    end
  end

  assign dout_valid = vld_q;

endmodule

// File: rtl/iconn_exchange_stage.sv
// Exchange half of one omega stage: PORT_NUM/2 switches plus a conflict counter.
// Define ICONN_EXCHANGE_STATS_EN to build the saturating conflict_cnt.
module iconn_exchange_stage
  import iconn_pkg::*;
#(
  parameter int NODE_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH      = 64,
  parameter int STAGE_IDX       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  iconn_exchange_stage_if.slave bus,
  output logic [15:0]           conflict_cnt
);

  localparam int PORT_NUM = port_num(NODE_ADDR_WIDTH);
  localparam int SW_NUM   = PORT_NUM / 2;

  if (STAGE_IDX < 0 || STAGE_IDX >= NODE_ADDR_WIDTH) begin : g_bad_stage
    $error("iconn_exchange_stage: STAGE_IDX %0d outside 0..%0d", STAGE_IDX, NODE_ADDR_WIDTH - 1);
  end

  logic [PORT_NUM-1:0]                      din_ready, dout_valid;
  logic [PORT_NUM-1:0][NODE_ADDR_WIDTH-1:0] aout;
  logic [PORT_NUM-1:0][DATA_WIDTH-1:0]      dout;
  logic [SW_NUM-1:0]                        sw_conflict;

  for (genvar k = 0; k < SW_NUM; k++) begin : g_sw
    iconn_exchange_switch #(
      .NODE_ADDR_WIDTH (NODE_ADDR_WIDTH),
      .DATA_WIDTH      (DATA_WIDTH),
      .STAGE_IDX       (STAGE_IDX)
    ) u_sw (
      .clk        (clk),
      .rst_n      (rst_n),
      .ain        (bus.ain[2*k+1 -: 2]),
      .din        (bus.din[2*k+1 -: 2]),
      .din_valid  (bus.din_valid[2*k+1 -: 2]),
      .din_ready  (din_ready[2*k+1 -: 2]),
      .aout       (aout[2*k+1 -: 2]),
      .dout       (dout[2*k+1 -: 2]),
      .dout_valid (dout_valid[2*k+1 -: 2]),
      .dout_ready (bus.dout_ready[2*k+1 -: 2]),
      .conflict   (sw_conflict[k])
    );
  end

  assign bus.din_ready  = din_ready;
  assign bus.aout       = aout;
  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;

`ifdef ICONN_EXCHANGE_STATS_EN
  logic [16:0] cnt_sum;
  logic [15:0] cnt_q;

  // One extra bit catches overflow; at most SW_NUM is added per cycle.
  always_comb begin
    cnt_sum = {1'b0, cnt_q};
    for (int k = 0; k < SW_NUM; k++) cnt_sum = cnt_sum + 17'(sw_conflict[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  assign conflict_cnt = cnt_q;
`else
  logic unused_conflict;
  assign unused_conflict = ^sw_conflict;
  assign conflict_cnt    = 16'h0;
`endif

endmodule

// File: tb/tb_iconn_exchange_stage.sv
// Scoreboarded bench for iconn_exchange_stage at NODE_ADDR_WIDTH=3, STAGE_IDX=0.
module tb_iconn_exchange_stage;

  localparam int NAW = 3;
  localparam int DW  = 16;
  localparam int PN  = 8;
`ifdef ICONN_EXCHANGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  iconn_exchange_stage_if #(.NODE_ADDR_WIDTH(NAW), .DATA_WIDTH(DW)) bus ();

  iconn_exchange_stage #(.NODE_ADDR_WIDTH(NAW), .DATA_WIDTH(DW), .STAGE_IDX(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  logic [NAW+DW-1:0] sb [PN][$];
  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int i, input logic [NAW-1:0] a, input logic [DW-1:0] d);
    bus.ain[i]       = a;
    bus.din[i]       = d;
    bus.din_valid[i] = 1'b1;
  endtask

  // Record every accepted token at its expected output, and model the counter.
  task automatic tick_neg();
    int nc;
    @(negedge clk);
    if (rst_n) begin
      nc = 0;
      for (int i = 0; i < PN; i++)
        if (bus.din_valid[i] && bus.din_ready[i])
          sb[2*(i/2) + int'(bus.ain[i][2])].push_back({bus.ain[i], bus.din[i]});
      for (int k = 0; k < PN/2; k++)
        if (bus.din_valid[2*k] && bus.din_valid[2*k+1] &&
            (bus.ain[2*k][2] == bus.ain[2*k+1][2]) &&
            (bus.din_ready[2*k] || bus.din_ready[2*k+1]))
          nc++;
      if (STATS) exp_cnt = (exp_cnt + nc > 65535) ? 65535 : exp_cnt + nc;
    end
  endtask

  task automatic tick_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    tick_neg();
    tick_pos();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int o = 0; o < PN; o++) begin
        if (bus.dout_valid[o] && bus.dout_ready[o]) begin
          logic [NAW+DW-1:0] e;
          checks++;
          if (sb[o].size() == 0) begin
            failures++;
            $display("FAIL sb_extra port=%0d actual=%h required=none", o, {bus.aout[o], bus.dout[o]});
          end else begin
            e = sb[o].pop_front();
            if ({bus.aout[o], bus.dout[o]} !== e) begin
              failures++;
              $display("FAIL sb_token port=%0d actual=%h required=%h", o, {bus.aout[o], bus.dout[o]}, e);
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL timeout actual=running required=done");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bus.ain = '0; bus.din = '0; bus.din_valid = '1; bus.dout_ready = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_din_ready", bus.din_ready, 0);
    chk("rst_cnt", conflict_cnt, 0);
    bus.din_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    tick_pos();

    // 1: independent targets on switch 0
    bus.dout_ready = '1;
    drive(0, 3'b000, 16'h1000);
    drive(1, 3'b100, 16'h1001);
    tick_neg();
    chk("t1_ready", bus.din_ready[1:0], 2'b11);
    tick_pos();
    bus.din_valid = '0;
    tick_neg();
    chk("t1_dout_valid", bus.dout_valid, 8'h03);
    chk("t1_dout0", bus.dout[0], 16'h1000);
    chk("t1_dout1", bus.dout[1], 16'h1001);
    tick_pos();

    // 2: persistent conflict on output 3 alternates grants
    for (int c = 0; c < 4; c++) begin
      drive(2, 3'b101, 16'(16'h2000 + 2*c));
      drive(3, 3'b101, 16'(16'h2001 + 2*c));
      tick_neg();
      chk("t2_grant", bus.din_ready[3:2], (c % 2 == 0) ? 2'b01 : 2'b10);
      tick_pos();
    end
    bus.din_valid = '0;
    tick_neg();
    chk("t2_cnt", conflict_cnt, STATS ? 4 : 0);
    tick_pos();

    // 3: backpressure on output 4, then drain+refill in one cycle
    bus.dout_ready[4] = 1'b0;
    drive(4, 3'b000, 16'h4000);
    tick_neg();
    chk("t3_first_ready", bus.din_ready[4], 1);
    tick_pos();
    drive(4, 3'b011, 16'h4001);
    for (int c = 0; c < 2; c++) begin
      tick_neg();
      chk("t3_blocked", bus.din_ready[4], 0);
      chk("t3_held_valid", bus.dout_valid[4], 1);
      chk("t3_held_data", bus.dout[4], 16'h4000);
      tick_pos();
    end
    bus.dout_ready[4] = 1'b1;
    tick_neg();
    chk("t3_refill_ready", bus.din_ready[4], 1);
    tick_pos();
    bus.din_valid = '0;
    tick_neg();
    chk("t3_new_valid", bus.dout_valid[4], 1);
    chk("t3_new_data", bus.dout[4], 16'h4001);
    chk("t3_new_addr", bus.aout[4], 3'b011);
    tick_pos();

    // 4: conflict against a blocked output keeps priority
    bus.dout_ready[0] = 1'b0;
    drive(0, 3'b000, 16'h5000);
    tick_neg();
    chk("t4_fill_ready", bus.din_ready[0], 1);
    tick_pos();
    drive(0, 3'b010, 16'h5001);
    drive(1, 3'b001, 16'h5002);
    for (int c = 0; c < 3; c++) begin
      tick_neg();
      chk("t4_blocked", bus.din_ready[1:0], 2'b00);
      tick_pos();
    end
    bus.dout_ready[0] = 1'b1;
    tick_neg();
    chk("t4_release", bus.din_ready[1:0], 2'b01);
    tick_pos();
    bus.din_valid = '0;
    cyc(); cyc();
    tick_neg();
    chk("t4_cnt", conflict_cnt, STATS ? 5 : 0);
    tick_pos();

    // 5: fill every output then reset asynchronously mid-cycle
    bus.dout_ready = '0;
    for (int i = 0; i < PN; i++) drive(i, (i % 2 == 1) ? 3'b100 : 3'b000, 16'(16'h6000 + i));
    tick_neg();
    chk("t5_fill_ready", bus.din_ready, 8'hFF);
    tick_pos();
    bus.din_valid = '0;
    tick_neg();
    chk("t5_full", bus.dout_valid, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", bus.dout_valid, 0);
    chk("t5_rst_dout", 64'(|bus.dout), 0);
    chk("t5_rst_aout", 64'(|bus.aout), 0);
    chk("t5_rst_cnt", conflict_cnt, 0);
    bus.din_valid = '1;
    #1;
    chk("t5_rst_ready", bus.din_ready, 0);
    bus.din_valid = '0;
    for (int o = 0; o < PN; o++) sb[o].delete();
    exp_cnt = 0;
    @(negedge clk); rst_n = 1'b1;
    tick_pos();
    bus.dout_ready = '1;
    drive(0, 3'b000, 16'h7000);
    drive(1, 3'b000, 16'h7001);
    tick_neg();
    chk("t5_prio_reset", bus.din_ready[1:0], 2'b01);
    chk("t5_cnt_zero", conflict_cnt, 0);
    tick_pos();
    bus.din_valid = '0;
    cyc(); cyc();

    // 6: random traffic against the scoreboard
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < PN; i++) begin
        bus.din_valid[i] = 1'($urandom_range(0, 1));
        bus.ain[i]       = 3'($urandom);
        bus.din[i]       = 16'($urandom);
      end
      bus.dout_ready = 8'($urandom);
      cyc();
      if (c % 2500 == 2499) chk("t6_cnt", conflict_cnt, STATS ? exp_cnt : 0);
    end
    bus.din_valid = '0;
    bus.dout_ready = '1;
    cyc(); cyc(); cyc();
    for (int o = 0; o < PN; o++) chk("t6_drained", sb[o].size(), 0);

    // 7: conflict on every switch every cycle until the counter saturates
    for (int c = 0; c < 17500; c++) begin
      for (int k = 0; k < PN/2; k++) begin
        logic b;
        b = 1'($urandom_range(0, 1));
        drive(2*k,   {b, 2'($urandom)}, 16'($urandom));
        drive(2*k+1, {b, 2'($urandom)}, 16'($urandom));
      end
      cyc();
    end
    bus.din_valid = '0;
    cyc(); cyc();
    chk("t7_saturated", conflict_cnt, STATS ? 16'hFFFF : 0);
    chk("t7_cnt_model", conflict_cnt, STATS ? exp_cnt : 0);
    for (int o = 0; o < PN; o++) chk("t7_drained", sb[o].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
